uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ byte producers, e.g. the solution assembler and a status/echo reporter.
- Grants the transmitter to one requester for a whole message, so bytes from different messages never interleave.
- Issues one tx_send pulse per byte and routes the transmitter's completion back to the owning requester.
- Round-robin between messages, with an inactivity timeout that frees a stalled owner.

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// A grant is held for a whole message; a stalled owner is released after HOLD_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned HOLD_TIMEOUT = 1000,
    parameter int unsigned ID_W         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 tx_send,
    output logic [7:0]           tx_byte,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 timeout_err
);

    localparam int unsigned CntW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StWaitDone, StHold} state_e;

    state_e          state;
    logic [ID_W-1:0] ptr;
    logic [CntW-1:0] hold_cnt;
    logic            last_flag;
    logic            tx_done_prev;

    logic            found;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] next_ptr;
    logic            done_edge;
    logic            owner_valid;
    logic [7:0]      owner_byte;
    logic            owner_last;

    assign done_edge   = tx_done & ~tx_done_prev;
    assign next_ptr    = ID_W'((int'(grant_id) + 1) % int'(NUM_REQ));
    assign owner_valid = req_valid[grant_id];
    assign owner_byte  = req_byte[{grant_id, 3'b000} +: 8];
    assign owner_last  = req_last[grant_id];

    // Scan downward so the candidate nearest the pointer is the last to win.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            cand = ID_W'((int'(ptr) + i) % int'(NUM_REQ));
            if (req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            ptr          <= '0;
            hold_cnt     <= '0;
            last_flag    <= 1'b0;
            tx_done_prev <= 1'b1;
            req_ack      <= '0;
            req_done     <= '0;
            tx_send      <= 1'b0;
            tx_byte      <= '0;
            busy         <= 1'b0;
            grant_id     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            tx_done_prev <= tx_done;
            req_ack      <= '0;
            req_done     <= '0;
            tx_send      <= 1'b0;
            timeout_err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (found) begin
                        grant_id <= winner;
                        busy     <= 1'b1;
                        state    <= StSend;
                    end
                end
                StSend: begin
                    tx_byte           <= owner_byte;
                    last_flag         <= owner_last;
                    tx_send           <= 1'b1;
                    req_ack[grant_id] <= 1'b1;
                    state             <= StWaitDone;
                end
                StWaitDone: begin
                    if (done_edge) begin
                        req_done[grant_id] <= 1'b1;
                        if (last_flag) begin
                            busy  <= 1'b0;
                            ptr   <= next_ptr;
                            state <= StIdle;
                        end else begin
                            hold_cnt <= '0;
                            state    <= StHold;
                        end
                    end
                end
                StHold: begin
                    // Launch straight from HOLD so a ready owner sees a one-cycle byte gap.
                    if (owner_valid) begin
                        tx_byte           <= owner_byte;
                        last_flag         <= owner_last;
                        tx_send           <= 1'b1;
                        req_ack[grant_id] <= 1'b1;
                        state             <= StWaitDone;
                    end else if (hold_cnt == CntW'(HOLD_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= StIdle;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a transmitter model drive the DUT; a
// message-order reference model predicts the byte stream, owners and completions.
module tb_uart_tx_arbiter;

    localparam int N   = 2;
    localparam int TO  = 8;
    localparam int IDW = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_byte;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   req_done;
    logic           tx_send;
    logic [7:0]     tx_byte;
    logic           tx_done;
    logic           busy;
    logic [IDW-1:0] grant_id;
    logic           timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .HOLD_TIMEOUT(TO),
        .ID_W        (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_byte   (req_byte),
        .req_last   (req_last),
        .req_ack    (req_ack),
        .req_done   (req_done),
        .tx_send    (tx_send),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .busy       (busy),
        .grant_id   (grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] rq[N][$];   // requester-side pending {last, byte}
    logic [8:0] mq[N][$];   // reference-model copy
    int sent_q[$];          // observed owner*256 + byte
    int exp_q[$];           // predicted owner*256 + byte
    int send_cyc_q[$];
    int done_cyc_q[$];
    int done_id_q[$];
    int to_cnt, to_cyc, m_ptr, rise_cyc;
    int tx_wait, tx_hi, tx_len_cur, cfg_delay, cfg_len;
    bit tx_force;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += rq[i].size();
        return s;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = rq[i][0][8];
                req_byte[8*i +: 8]   = rq[i][0][7:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_byte[8*i +: 8]   = 8'h00;
            end
        end
    endtask

    task automatic step();
        logic prev;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_send) begin
            send_cyc_q.push_back(cyc);
            sent_q.push_back(int'(grant_id) * 256 + int'(tx_byte));
            check("ack_with_send", 32'(req_ack), 32'(1 << grant_id));
            tx_wait    = (cfg_delay != 0) ? cfg_delay : int'($urandom_range(6, 25));
            tx_len_cur = (cfg_len != 0) ? cfg_len : int'($urandom_range(1, 5));
        end else if (req_ack != '0) begin
            check("ack_without_send", 32'(req_ack), 32'h0);
        end else if (tx_wait > 0) begin
            tx_wait--;
            if (tx_wait == 0) tx_hi = tx_len_cur;
        end
        for (int i = 0; i < N; i++) begin
            if (req_done[i]) begin
                done_cyc_q.push_back(cyc);
                done_id_q.push_back(i);
                check("done_latency", cyc, rise_cyc + 1);
            end
        end
        if (timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        prev = tx_done;
        if (tx_hi > 0) begin
            tx_done = 1'b1;
            tx_hi--;
        end else begin
            tx_done = tx_force;
        end
        if (tx_done && !prev) rise_cyc = cyc;
        drive();
    endtask

    task automatic add_msg(input int r, input int len, input bit fin = 1'b1);
        logic [8:0] e;
        for (int k = 0; k < len; k++) begin
            e[7:0] = 8'($urandom_range(0, 255));
            e[8]   = fin && (k == len - 1);
            rq[r].push_back(e);
            mq[r].push_back(e);
        end
        drive();
    endtask

    // Whole messages leave in round-robin order of requesters that have one pending.
    task automatic expect_msgs();
        logic [8:0] e;
        int sel;
        int s;
        forever begin
            s = 0;
            for (int i = 0; i < N; i++) s += mq[i].size();
            if (s == 0) break;
            sel = -1;
            for (int o = 0; o < N; o++) begin
                if (sel < 0 && mq[(m_ptr + o) % N].size() > 0) sel = (m_ptr + o) % N;
            end
            do begin
                e = mq[sel].pop_front();
                exp_q.push_back(sel * 256 + int'(e[7:0]));
            end while (!e[8] && mq[sel].size() > 0);
            m_ptr = (sel + 1) % N;
        end
    endtask

    task automatic settle(input int budget);
        int idle = 0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (busy === 1'b0 && pending() == 0 && tx_wait == 0 && tx_hi == 0) idle++;
            else idle = 0;
            if (idle >= 4) return;
        end
        check("settle_budget", 32'd0, 32'd1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_sent_count"}, sent_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            check({tag, "_sent_item"}, sent_q[i], exp_q[i]);
        check({tag, "_done_count"}, done_id_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < done_id_q.size(); i++)
            check({tag, "_done_owner"}, done_id_q[i], exp_q[i] / 256);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        sent_q.delete();
        exp_q.delete();
        send_cyc_q.delete();
        done_cyc_q.delete();
        done_id_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            mq[i].delete();
        end
        drive();
        step();
        check("rst_outputs",
              32'({req_ack, req_done, tx_send, tx_byte, busy, grant_id, timeout_err}), 32'd0);
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        int enq_cyc;
        rst = 1'b1;
        req_valid = '0;
        req_byte = '0;
        req_last = '0;
        tx_done = 1'b1;
        tx_force = 1'b1;
        to_cnt = 0;
        to_cyc = 0;
        rise_cyc = -10;
        tx_wait = 0;
        tx_hi = 0;
        tx_len_cur = 1;
        cfg_delay = 0;
        cfg_len = 0;
        m_ptr = 0;

        // Reset held while tx_done is already high.
        step();
        do_reset();
        repeat (6) step();
        tx_force = 1'b0;
        repeat (6) step();
        check("no_done_after_reset", done_id_q.size(), 0);

        // Single message 0xE0, 0x04.
        cfg_delay = 20;
        cfg_len   = 2;
        rq[0].push_back({1'b0, 8'hE0});
        mq[0].push_back({1'b0, 8'hE0});
        rq[0].push_back({1'b1, 8'h04});
        mq[0].push_back({1'b1, 8'h04});
        enq_cyc = cyc;
        drive();
        expect_msgs();
        settle(500);
        if (send_cyc_q.size() >= 2 && done_cyc_q.size() >= 1) begin
            check("first_send_latency", send_cyc_q[0], enq_cyc + 2);
            check("hold_byte_gap", send_cyc_q[1], done_cyc_q[0] + 1);
        end else begin
            check("single_events_seen", 32'd0, 32'd1);
        end
        compare("single");

        // Timeout: pointer is now 1, so requester 1 wins and stalls mid-message.
        cfg_delay = 0;
        cfg_len   = 0;
        to_cnt    = 0;
        add_msg(1, 1, 1'b0);
        add_msg(0, 1);
        expect_msgs();
        settle(1000);
        check("timeout_count", to_cnt, 1);
        if (done_cyc_q.size() > 0) check("timeout_delay", to_cyc, done_cyc_q[0] + TO);
        else check("timeout_done_seen", 32'd0, 32'd1);
        compare("timeout");

        // Contention right after reset.
        do_reset();
        add_msg(0, 2);
        add_msg(1, 2);
        expect_msgs();
        settle(1000);
        compare("contention");

        // Fairness with back-to-back single-byte messages.
        for (int k = 0; k < 3; k++) begin
            add_msg(0, 1);
            add_msg(1, 1);
        end
        expect_msgs();
        settle(2000);
        check("fair_last_owner", 32'(grant_id), 32'd1);
        compare("fair");

        // Random message mixes.
        for (int round = 0; round < 3; round++) begin
            for (int r = 0; r < N; r++) begin
                for (int m = 0; m < int'($urandom_range(1, 3)); m++) add_msg(r, int'($urandom_range(1, 4)));
            end
            expect_msgs();
            settle(4000);
            compare("random");
        end

        // Long tx_done level counts once.
        cfg_len = 5;
        add_msg(0, 1);
        expect_msgs();
        settle(500);
        compare("long_done");
        cfg_len = 0;

        // Reset mid-message: move pointer to 1 first, abort requester 1 during WAIT_DONE.
        add_msg(0, 1);
        expect_msgs();
        settle(500);
        compare("pre_abort");
        cfg_delay = 20;
        add_msg(1, 2);
        for (int n = 0; n < 20; n++) begin
            if (send_cyc_q.size() == 0) step();
        end
        check("abort_send_seen", send_cyc_q.size(), 1);
        repeat (3) step();
        do_reset();
        sent_q.delete();
        send_cyc_q.delete();
        settle(100);
        check("abort_no_done", done_id_q.size(), 0);
        cfg_delay = 0;
        add_msg(0, 1);
        add_msg(1, 1);
        expect_msgs();
        settle(1000);
        compare("post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
